// File: rtl/majority_pkg.sv
// Shared helpers for the N-channel majority voter: channel popcount,
// effective vote threshold and saturating-counter limit.
package majority_pkg;

   localparam int MAX_CH = 32;

   typedef logic [MAX_CH-1:0] ch_vec_t;
   typedef logic [5:0]        cnt_t;

   // Counts set bits among the low n_ch channels; callers zero-extend into ch_vec_t.
   function automatic cnt_t popcount(input ch_vec_t v, input int n_ch);
      cnt_t n;
      n = '0;
      for (int i = 0; i < MAX_CH; i++) begin
         if (i < n_ch) n = n + cnt_t'(v[i]);
      end
      return n;
   endfunction

   // Out-of-range thresholds fall back to strict majority, so even-count ties vote 0.
   function automatic cnt_t eff_threshold(input cnt_t thr, input cnt_t a_cnt);
      if (thr != '0 && thr <= a_cnt) return thr;
      return (a_cnt >> 1) + cnt_t'(1);
   endfunction

   function automatic logic [63:0] cnt_max(input int w);
      return (64'd1 << w) - 64'd1;
   endfunction

endpackage

// File: rtl/maj_channel_monitor.sv
// Per-channel disagreement tracker: consecutive-miss counter, sticky fault
// flag and saturating total-mismatch counter.
module maj_channel_monitor
   import majority_pkg::*;
#(
   parameter int FAULT_LIM = 4,
   parameter int CNT_W     = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             vote_valid,
   input  logic             disagree_i,
   input  logic             fault_clr,
   output logic             fault_o,
   output logic [CNT_W-1:0] mis_cnt_o
);

   localparam int               CW      = $clog2(FAULT_LIM + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));

   logic [CW-1:0]    consec_q, consec_d;
   logic             fault_q, fault_d;
   logic [CNT_W-1:0] mis_q, mis_d;

   // NOTE: every next-state signal takes its current value first, so no path leaves it unassigned (no latch).
   always_comb begin
      consec_d = consec_q;
      fault_d  = fault_q;
      mis_d    = mis_q;
      if (vote_valid && !fault_q) begin
         if (disagree_i) begin
            consec_d = consec_q + CW'(1);
            if (mis_q != CNT_MAX) mis_d = mis_q + CNT_W'(1);
            if (consec_d == CW'(FAULT_LIM)) fault_d = 1'b1;
         end else begin
            consec_d = '0;
         end
      end
      // A clear coincident with a vote still keeps that vote's mis_cnt update.
      if (fault_clr) begin
         fault_d  = 1'b0;
         consec_d = '0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         consec_q <= '0;
         fault_q  <= 1'b0;
         mis_q    <= '0;
      end else begin
         consec_q <= consec_d;
         fault_q  <= fault_d;
         mis_q    <= mis_d;
      end
   end

   assign fault_o   = fault_q;
   assign mis_cnt_o = mis_q;

endmodule

// File: rtl/majority_voter_n.sv
// Registered N-channel bitwise majority voter with programmable threshold,
// per-channel fault masking and mismatch statistics.
module majority_voter_n
   import majority_pkg::*;
#(
   parameter  int N_CH      = 3,
   parameter  int WIDTH     = 8,
   parameter  int FAULT_LIM = 4,
   parameter  int CNT_W     = 8,
   localparam int TW        = $clog2(N_CH + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   input  logic [N_CH*WIDTH-1:0] in_data,
   input  logic [TW-1:0]         thr,
   input  logic                  fault_clr,
   output logic                  out_valid,
   output logic [WIDTH-1:0]      out_data,
   output logic [N_CH-1:0]       disagree,
   output logic [N_CH-1:0]       fault,
   output logic                  no_quorum,
   output logic [N_CH*CNT_W-1:0] mis_cnt
);

   logic [N_CH-1:0]  active, dis_vec, fault_w;
   cnt_t             a_cnt, t_eff, ones;
   logic             quorum, vote_go;
   logic [WIDTH-1:0] vote_w;

   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic [N_CH-1:0]  disagree_q, disagree_d;
   logic             no_quorum_q, no_quorum_d;

   always_comb begin
      active = ~fault_w;
      a_cnt  = popcount(ch_vec_t'(active), N_CH);
      t_eff  = eff_threshold(cnt_t'(thr), a_cnt);
      quorum = (a_cnt != '0);
      ones   = '0;
      vote_w = '0;
      for (int b = 0; b < WIDTH; b++) begin
         ones = '0;
         for (int c = 0; c < N_CH; c++) begin
            if (active[c] && in_data[c*WIDTH+b]) ones = ones + cnt_t'(1);
         end
         vote_w[b] = (ones >= t_eff);
      end
      for (int c = 0; c < N_CH; c++) begin
         dis_vec[c] = active[c] && (in_data[c*WIDTH +: WIDTH] != vote_w);
      end
   end

   assign vote_go = in_valid && quorum;

   always_comb begin
      out_valid_d = in_valid;
      out_data_d  = out_data_q;
      disagree_d  = disagree_q;
      no_quorum_d = 1'b0;
      if (in_valid) begin
         if (quorum) begin
            out_data_d = vote_w;
            disagree_d = dis_vec;
         end else begin
            disagree_d  = '0;
            no_quorum_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         disagree_q  <= '0;
         no_quorum_q <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         disagree_q  <= disagree_d;
         no_quorum_q <= no_quorum_d;
      end
   end

   for (genvar g = 0; g < N_CH; g++) begin : g_mon
      maj_channel_monitor #(
         .FAULT_LIM (FAULT_LIM),
         .CNT_W     (CNT_W)
      ) u_mon (
         .clk        (clk),
         .rst        (rst),
         .vote_valid (vote_go),
         .disagree_i (dis_vec[g]),
         .fault_clr  (fault_clr),
         .fault_o    (fault_w[g]),
         .mis_cnt_o  (mis_cnt[g*CNT_W +: CNT_W])
      );
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign disagree  = disagree_q;
   assign no_quorum = no_quorum_q;
   assign fault     = fault_w;

endmodule

// File: tb/tb_majority_voter_n.sv
// Scoreboard bench for majority_voter_n: driver pushes model results per cycle,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_majority_voter_n;

   localparam int N_CH      = 3;
   localparam int WIDTH     = 8;
   localparam int FAULT_LIM = 4;
   localparam int CNT_W     = 8;

   bit          clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [23:0] in_data;
   logic [1:0]  thr;
   logic        fault_clr;
   logic        out_valid;
   logic [7:0]  out_data;
   logic [2:0]  disagree;
   logic [2:0]  fault;
   logic        no_quorum;
   logic [23:0] mis_cnt;

   majority_voter_n #(
      .N_CH      (N_CH),
      .WIDTH     (WIDTH),
      .FAULT_LIM (FAULT_LIM),
      .CNT_W     (CNT_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .thr       (thr),
      .fault_clr (fault_clr),
      .out_valid (out_valid),
      .out_data  (out_data),
      .disagree  (disagree),
      .fault     (fault),
      .no_quorum (no_quorum),
      .mis_cnt   (mis_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          valid;
      logic [7:0]  data;
      logic [2:0]  dis;
      bit          nq;
      logic [2:0]  fault;
      logic [23:0] mis;
   } exp_t;

   exp_t sb_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   // Reference state: one entry per channel, plain integers.
   int         m_fault[3];
   int         m_consec[3];
   int         m_mis[3];
   logic [7:0] m_data;
   logic [2:0] m_dis;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model(input bit r, input bit v, input logic [23:0] d,
                        input logic [1:0] t, input bit clr, output exp_t e);
      int         act[$];
      int         n, thr_e, ones, c;
      logic [7:0] vote;
      bit         nq;
      nq = 1'b0;
      if (r) begin
         for (int i = 0; i < 3; i++) begin
            m_fault[i] = 0; m_consec[i] = 0; m_mis[i] = 0;
         end
         m_data = 8'h00;
         m_dis  = 3'b000;
         e.valid = 1'b0;
      end else begin
         e.valid = v;
         if (v) begin
            for (int i = 0; i < 3; i++) if (m_fault[i] == 0) act.push_back(i);
            n = act.size();
            if (n == 0) begin
               nq    = 1'b1;
               m_dis = 3'b000;
            end else begin
               thr_e = (t >= 1 && int'(t) <= n) ? int'(t) : n / 2 + 1;
               vote  = 8'h00;
               for (int b = 0; b < 8; b++) begin
                  ones = 0;
                  foreach (act[k]) ones += int'(d[act[k]*8+b]);
                  vote[b] = (ones >= thr_e);
               end
               m_data = vote;
               m_dis  = 3'b000;
               foreach (act[k]) begin
                  c = act[k];
                  if (d[c*8 +: 8] != vote) begin
                     m_dis[c]    = 1'b1;
                     m_mis[c]    = (m_mis[c] < 255) ? m_mis[c] + 1 : 255;
                     m_consec[c] = m_consec[c] + 1;
                     if (m_consec[c] == FAULT_LIM) m_fault[c] = 1;
                  end else begin
                     m_consec[c] = 0;
                  end
               end
            end
         end
         if (clr) begin
            for (int i = 0; i < 3; i++) begin
               m_fault[i] = 0; m_consec[i] = 0;
            end
         end
      end
      e.data  = m_data;
      e.dis   = m_dis;
      e.nq    = nq;
      e.fault = {m_fault[2] != 0, m_fault[1] != 0, m_fault[0] != 0};
      e.mis   = {8'(m_mis[2]), 8'(m_mis[1]), 8'(m_mis[0])};
   endtask

   task automatic step(input bit r, input bit v, input logic [23:0] d,
                       input logic [1:0] t, input bit clr);
      exp_t e;
      rst       = r;
      in_valid  = v;
      in_data   = d;
      thr       = t;
      fault_clr = clr;
      model(r, v, d, t, clr, e);
      sb_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         check("out_valid", 32'(out_valid), 32'(e.valid));
         check("out_data",  32'(out_data),  32'(e.data));
         check("disagree",  32'(disagree),  32'(e.dis));
         check("no_quorum", 32'(no_quorum), 32'(e.nq));
         check("fault",     32'(fault),     32'(e.fault));
         check("mis_cnt",   32'(mis_cnt),   32'(e.mis));
      end
   end

   initial begin
      logic [7:0]  base;
      logic [23:0] d;
      rst = 1'b1; in_valid = 1'b0; in_data = '0; thr = '0; fault_clr = 1'b0;

      repeat (2) step(1'b1, 1'b0, 24'h0, 2'd0, 1'b0);

      // Single mismatching channel, repeated until it faults.
      repeat (4) step(1'b0, 1'b1, {8'h5A, 8'hA5, 8'hA5}, 2'd0, 1'b0);
      step(1'b0, 1'b1, {8'h33, 8'h00, 8'hFF}, 2'd0, 1'b0);

      // Explicit and out-of-range thresholds with two active channels.
      step(1'b0, 1'b1, {8'h33, 8'h0F, 8'hF0}, 2'd1, 1'b0);
      step(1'b0, 1'b1, {8'h33, 8'h0F, 8'hF0}, 2'd3, 1'b0);
      step(1'b0, 1'b0, 24'h0, 2'd0, 1'b0);

      // Interrupted mismatch run on ch1 must not fault.
      step(1'b1, 1'b0, 24'h0, 2'd0, 1'b0);
      step(1'b0, 1'b1, {8'hA5, 8'h5A, 8'hA5}, 2'd0, 1'b0);
      step(1'b0, 1'b1, {8'hA5, 8'hA5, 8'hA5}, 2'd0, 1'b0);
      repeat (3) step(1'b0, 1'b1, {8'hA5, 8'h5A, 8'hA5}, 2'd0, 1'b0);

      // Saturate ch0's total counter while periodic clears keep it unfaulted.
      step(1'b1, 1'b0, 24'h0, 2'd0, 1'b0);
      for (int i = 0; i < 270; i++)
         step(1'b0, 1'b1, {8'h11, 8'h11, 8'hEE}, 2'd0, (i % 3) == 2);

      // All channels fault, then no-quorum, clear with concurrent vote, reset mid-stream.
      step(1'b1, 1'b0, 24'h0, 2'd0, 1'b0);
      repeat (4) step(1'b0, 1'b1, {8'h04, 8'h02, 8'h01}, 2'd0, 1'b0);
      step(1'b0, 1'b1, {8'hFF, 8'hFF, 8'hFF}, 2'd0, 1'b0);
      step(1'b0, 1'b1, {8'hFF, 8'hFF, 8'hFF}, 2'd0, 1'b1);
      step(1'b0, 1'b1, {8'hFF, 8'hFF, 8'hFF}, 2'd0, 1'b0);
      step(1'b0, 1'b0, 24'h0, 2'd0, 1'b0);
      step(1'b1, 1'b1, {8'h12, 8'h34, 8'h56}, 2'd0, 1'b0);
      step(1'b0, 1'b0, 24'h0, 2'd0, 1'b0);

      // Randomized traffic: mostly-agreeing channels with occasional bit flips.
      for (int i = 0; i < 400; i++) begin
         base = 8'($urandom);
         for (int c = 0; c < 3; c++)
            d[c*8 +: 8] = base ^ (($urandom_range(3) == 0) ? 8'($urandom) : 8'h00);
         step($urandom_range(149) == 0, $urandom_range(3) != 0, d,
              2'($urandom_range(3)), $urandom_range(24) == 0);
      end
      step(1'b0, 1'b0, 24'h0, 2'd0, 1'b0);

      @(negedge clk);
      #1;
      check("sb_drain", 32'(sb_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
